pipe_hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage core.
- Generates per-stage stall and bubble (nop) controls for the IF/ID, ID/EX and EX/MEM pipeline registers.
- Issues the front-end redirect on EX mispredict.
- Sequences fence.i as drain, then icache flush, then refetch.
- Purely a controller: holds no instruction data, only hazard state, pending redirect and fence bookkeeping.

---
 rtl/pipe_hazard_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central hazard/sequencing controller for the 5-stage pipeline. It produces
// the stall and bubble controls for the IF/ID, ID/EX and EX/MEM pipeline
// registers. It issues front-end redirects on EX mispredicts. It also
// sequences fence.i as drain -> icache flush -> refetch. The block holds no
// instruction data. Its only state is the sequencer, the drain counter, a
// pending redirect and the fence return PC.
//
// Optional feature: define PIPE_HAZARD_CTRL_PERF_EN to add the saturating
// performance counters perf_stall_cyc and perf_flush_cnt.
//
// Ports:
//   clock, reset             core clock, synchronous active-high reset
//   ex_is_load, ex_rd        load-in-EX indication and its destination
//   id_rs1_en/id_rs1,
//   id_rs2_en/id_rs2         source operands read by the ID instruction
//   id_fence_i, id_pc        fence.i present in ID and its PC
//   ex_redirect(_pc)         one-cycle EX mispredict and the correct target
//   ex_busy, mem_busy        multi-cycle EX op / LSU waiting on memory
//   icache_flush_ack         icache invalidate complete (pulse)
//   if_stall/id_stall/
//   ex_stall                 hold PC+IF/ID, ID/EX, EX/MEM
//   if_id_nop/id_ex_nop/
//   ex_mem_nop               load a bubble into the matching register
//   redirect_valid/_pc       front-end redirect pulse and target
//   icache_flush_req         icache invalidate request, level until ack
//   perf_stall_cyc,
//   perf_flush_cnt           (PERF_EN only) if_stall cycles / redirects
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int PC_W      = 64,
    parameter int REG_AW    = 5,
    parameter int DRAIN_CYC = 3   // legal range 1..15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_rs1_en,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic              id_rs2_en,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_fence_i,
    input  logic [PC_W-1:0]   id_pc,
    input  logic              ex_redirect,
    input  logic [PC_W-1:0]   ex_redirect_pc,
    input  logic              ex_busy,
    input  logic              mem_busy,
    input  logic              icache_flush_ack,
    output logic              if_stall,
    output logic              id_stall,
    output logic              ex_stall,
    output logic              if_id_nop,
    output logic              id_ex_nop,
    output logic              ex_mem_nop,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              icache_flush_req
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_stall_cyc,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]      state;
    logic [3:0]      drain_cnt;
    logic            pending_redir;
    logic [PC_W-1:0] pending_pc;
    logic [PC_W-1:0] fence_pc;
    logic [PC_W-1:0] redirect_pc_q;

    logic            load_use;
    logic            fence_done;
    logic            redir_issue;
    logic [PC_W-1:0] fence_ret_pc;
    logic [PC_W-1:0] redir_target;

    // Return address after fence.i; the add wraps modulo 2^PC_W.
    assign fence_ret_pc = fence_pc + PC_W'(4);

    assign load_use = (state == ST_RUN) && ex_is_load && (ex_rd != '0) &&
                      ((id_rs1_en && (id_rs1 == ex_rd)) ||
                       (id_rs2_en && (id_rs2 == ex_rd)));

    // A flush ack completes the fence only if no redirect is already queued.
    // A queued or live redirect aborts the fence, so the ack is then stale.
    assign fence_done = (state == ST_FLUSH) && icache_flush_ack && !pending_redir;

    assign redir_issue = !reset && !mem_busy &&
                         (ex_redirect || pending_redir || fence_done);

    // Live mispredict beats a queued one, and both beat fence completion.
    always_comb begin
        if (ex_redirect)
            redir_target = ex_redirect_pc;
        else if (pending_redir)
            redir_target = pending_pc;
        else
            redir_target = fence_ret_pc;
    end

    // NOTE: every output gets a default at the top of this block, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        if_stall         = 1'b0;
        id_stall         = 1'b0;
        ex_stall         = 1'b0;
        if_id_nop        = 1'b0;
        id_ex_nop        = 1'b0;
        ex_mem_nop       = 1'b0;
        redirect_valid   = 1'b0;
        icache_flush_req = 1'b0;
        if (!reset) begin
            if (mem_busy) begin
                if_stall         = 1'b1;
                id_stall         = 1'b1;
                ex_stall         = 1'b1;
                icache_flush_req = (state == ST_FLUSH);
            end else if (redir_issue) begin
                redirect_valid = 1'b1;
                if_id_nop      = 1'b1;
                id_ex_nop      = 1'b1;
            end else if (ex_busy) begin
                if_stall         = 1'b1;
                id_stall         = 1'b1;
                ex_stall         = 1'b1;
                ex_mem_nop       = 1'b1;
                icache_flush_req = (state == ST_FLUSH);
            end else if (state != ST_RUN || load_use || id_fence_i) begin
                // Drain, flush, load-use bubble and fence entry all freeze
                // the front end and feed a bubble into EX.
                if_stall         = 1'b1;
                id_stall         = 1'b1;
                id_ex_nop        = 1'b1;
                icache_flush_req = (state == ST_FLUSH);
            end
        end
    end

    assign redirect_pc = reset          ? '0           :
                         redirect_valid ? redir_target : redirect_pc_q;

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then updates from the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_RUN;
            drain_cnt     <= '0;
            pending_redir <= 1'b0;
            pending_pc    <= '0;
            fence_pc      <= '0;
            redirect_pc_q <= '0;
        end else if (mem_busy) begin
            // Nothing may issue while memory is busy. A redirect arriving now
            // is queued. A fence completion is turned into a queued redirect
            // so the ack pulse is not lost.
            if (ex_redirect) begin
                pending_redir <= 1'b1;
                pending_pc    <= ex_redirect_pc;
            end else if (fence_done) begin
                pending_redir <= 1'b1;
                pending_pc    <= fence_ret_pc;
                state         <= ST_RUN;
                drain_cnt     <= '0;
            end
        end else if (redir_issue) begin
            state         <= ST_RUN;
            drain_cnt     <= '0;
            pending_redir <= 1'b0;
            redirect_pc_q <= redir_target;
        end else if (!ex_busy) begin
            case (state)
                ST_RUN: begin
                    if (id_fence_i && !load_use) begin
                        fence_pc  <= id_pc;
                        state     <= ST_DRAIN;
                        drain_cnt <= 4'(DRAIN_CYC);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt <= 4'd1) begin
                        drain_cnt <= '0;
                        state     <= ST_FLUSH;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (if_stall && (perf_stall_cyc != '1))
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (redirect_valid && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Self-checking bench for pipe_hazard_ctrl. A behavioural model applies the
// per-cycle priority rules (reset, mem_busy, redirect, ex_busy, load-use,
// fence.i) to a small set of variables. Directed scenarios run first, then
// randomized traffic. Every cycle the outputs are compared with the model.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int PC_W      = 64;
    localparam int REG_AW    = 5;
    localparam int DRAIN_CYC = 3;

    typedef struct {
        logic        reset;
        logic        ex_is_load;
        logic [4:0]  ex_rd;
        logic        id_rs1_en;
        logic [4:0]  id_rs1;
        logic        id_rs2_en;
        logic [4:0]  id_rs2;
        logic        id_fence_i;
        logic [63:0] id_pc;
        logic        ex_redirect;
        logic [63:0] ex_redirect_pc;
        logic        ex_busy;
        logic        mem_busy;
        logic        icache_flush_ack;
    } stim_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              ex_is_load;
    logic [REG_AW-1:0] ex_rd;
    logic              id_rs1_en;
    logic [REG_AW-1:0] id_rs1;
    logic              id_rs2_en;
    logic [REG_AW-1:0] id_rs2;
    logic              id_fence_i;
    logic [PC_W-1:0]   id_pc;
    logic              ex_redirect;
    logic [PC_W-1:0]   ex_redirect_pc;
    logic              ex_busy;
    logic              mem_busy;
    logic              icache_flush_ack;
    logic              if_stall, id_stall, ex_stall;
    logic              if_id_nop, id_ex_nop, ex_mem_nop;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              icache_flush_req;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0]       perf_stall_cyc;
    logic [31:0]       perf_flush_cnt;
`endif

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(
        .PC_W      (PC_W),
        .REG_AW    (REG_AW),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .ex_is_load       (ex_is_load),
        .ex_rd            (ex_rd),
        .id_rs1_en        (id_rs1_en),
        .id_rs1           (id_rs1),
        .id_rs2_en        (id_rs2_en),
        .id_rs2           (id_rs2),
        .id_fence_i       (id_fence_i),
        .id_pc            (id_pc),
        .ex_redirect      (ex_redirect),
        .ex_redirect_pc   (ex_redirect_pc),
        .ex_busy          (ex_busy),
        .mem_busy         (mem_busy),
        .icache_flush_ack (icache_flush_ack),
        .if_stall         (if_stall),
        .id_stall         (id_stall),
        .ex_stall         (ex_stall),
        .if_id_nop        (if_id_nop),
        .id_ex_nop        (id_ex_nop),
        .ex_mem_nop       (ex_mem_nop),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .icache_flush_req (icache_flush_req)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        ,
        .perf_stall_cyc   (perf_stall_cyc),
        .perf_flush_cnt   (perf_flush_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 = running, 1 = draining, 2 = waiting for icache flush
    int          m_mode     = 0;
    int          m_left     = 0;
    bit          m_pend     = 0;
    logic [63:0] m_pend_pc  = '0;
    logic [63:0] m_fence_pc = '0;
    logic [63:0] m_rpc      = '0;
    longint      m_perf_stall = 0;
    longint      m_perf_flush = 0;

    stim_t s;

    task automatic idle();
        s = '{reset: 1'b0, ex_is_load: 1'b0, ex_rd: '0, id_rs1_en: 1'b0, id_rs1: '0,
              id_rs2_en: 1'b0, id_rs2: '0, id_fence_i: 1'b0, id_pc: '0,
              ex_redirect: 1'b0, ex_redirect_pc: '0, ex_busy: 1'b0,
              mem_busy: 1'b0, icache_flush_ack: 1'b0};
    endtask

    // Drives the staged stimulus for one cycle and checks every output.
    // It then advances the model to the state the next clock edge produces.
    task automatic step();
        bit          hazard, fdone, has_redir;
        logic [63:0] tgt;
        logic [7:0]  e;   // {if,id,ex stall, if_id,id_ex,ex_mem nop, rv, flush_req}
        logic [7:0]  got;
        logic [63:0] e_pc;
        @(negedge clock);
        reset = s.reset; ex_is_load = s.ex_is_load; ex_rd = s.ex_rd;
        id_rs1_en = s.id_rs1_en; id_rs1 = s.id_rs1; id_rs2_en = s.id_rs2_en;
        id_rs2 = s.id_rs2; id_fence_i = s.id_fence_i; id_pc = s.id_pc;
        ex_redirect = s.ex_redirect; ex_redirect_pc = s.ex_redirect_pc;
        ex_busy = s.ex_busy; mem_busy = s.mem_busy; icache_flush_ack = s.icache_flush_ack;
        #1;
        hazard = (m_mode == 0) && s.ex_is_load && (s.ex_rd != 0) &&
                 ((s.id_rs1_en && s.id_rs1 == s.ex_rd) || (s.id_rs2_en && s.id_rs2 == s.ex_rd));
        fdone     = (m_mode == 2) && s.icache_flush_ack && !m_pend;
        has_redir = s.ex_redirect || m_pend || fdone;
        tgt       = s.ex_redirect ? s.ex_redirect_pc : (m_pend ? m_pend_pc : m_fence_pc + 64'd4);
        e = 8'b0;
        if (!s.reset) begin
            if (s.mem_busy)                               e = {7'b1110000, m_mode == 2};
            else if (has_redir)                           e = 8'b00011010;
            else if (s.ex_busy)                           e = {7'b1110010, m_mode == 2};
            else if (m_mode != 0 || hazard || s.id_fence_i) e = {7'b1100100, m_mode == 2};
        end
        e_pc = s.reset ? 64'd0 : (e[1] ? tgt : m_rpc);
        got = {if_stall, id_stall, ex_stall, if_id_nop, id_ex_nop, ex_mem_nop,
               redirect_valid, icache_flush_req};
        check("ctl", 64'(got), 64'(e));
        check("rpc", redirect_pc, e_pc);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        check("perf_stall", 64'(perf_stall_cyc), 64'(m_perf_stall));
        check("perf_flush", 64'(perf_flush_cnt), 64'(m_perf_flush));
`endif
        if (s.reset) begin
            m_mode = 0; m_left = 0; m_pend = 0; m_pend_pc = '0; m_fence_pc = '0; m_rpc = '0;
            m_perf_stall = 0; m_perf_flush = 0;
        end else begin
            if (e[7] && m_perf_stall < 64'hFFFF_FFFF) m_perf_stall++;
            if (e[1] && m_perf_flush < 64'hFFFF_FFFF) m_perf_flush++;
            if (s.mem_busy) begin
                if (s.ex_redirect) begin
                    m_pend = 1; m_pend_pc = s.ex_redirect_pc;
                end else if (fdone) begin
                    m_pend = 1; m_pend_pc = m_fence_pc + 64'd4; m_mode = 0;
                end
            end else if (has_redir) begin
                m_rpc = tgt; m_pend = 0; m_mode = 0; m_left = 0;
            end else if (!s.ex_busy) begin
                if (m_mode == 1) begin
                    m_left--;
                    if (m_left == 0) m_mode = 2;
                end else if (m_mode == 0 && s.id_fence_i && !hazard) begin
                    m_fence_pc = s.id_pc; m_mode = 1; m_left = DRAIN_CYC;
                end
            end
        end
    endtask

    task automatic start_fence(input logic [63:0] pc);
        idle(); s.id_fence_i = 1'b1; s.id_pc = pc; step();
        idle();
        for (int i = 0; i < DRAIN_CYC; i++) begin
            step();
            check("drain_no_req", 64'(icache_flush_req), 64'd0);
        end
    endtask

    initial begin
        idle(); s.reset = 1'b1; step(); step();
        check("rst_ctl", 64'({if_stall, id_stall, ex_stall, redirect_valid, icache_flush_req}), 64'd0);
        idle(); step();

        // Load-use: exactly one bubble; then the same pattern with x0 gives none.
        s.ex_is_load = 1'b1; s.ex_rd = 5'd5; s.id_rs2_en = 1'b1; s.id_rs2 = 5'd5; step();
        check("lu_bubble", 64'({if_stall, id_stall, id_ex_nop}), 64'b111);
        idle(); step();
        check("lu_once", 64'(if_stall), 64'd0);
        s.ex_is_load = 1'b1; s.ex_rd = 5'd0; s.id_rs2_en = 1'b1; s.id_rs2 = 5'd0; step();
        check("lu_x0", 64'(if_stall), 64'd0);

        // Redirect arriving while memory is busy is issued once memory frees.
        idle(); s.mem_busy = 1'b1; step();
        s.ex_redirect = 1'b1; s.ex_redirect_pc = 64'h8000_0100; step();
        check("mb_no_issue", 64'(redirect_valid), 64'd0);
        idle(); s.mem_busy = 1'b1; step();
        idle(); step();
        check("mb_issue", 64'({redirect_valid, if_id_nop, id_ex_nop}), 64'b111);
        check("mb_pc", redirect_pc, 64'h8000_0100);
        step();
        check("mb_pulse", 64'(redirect_valid), 64'd0);

        // fence.i: drain, flush held for 5 cycles, then refetch at pc+4.
        start_fence(64'h8000_0040);
        for (int i = 0; i < 5; i++) begin
            step();
            check("flush_req", 64'(icache_flush_req), 64'd1);
        end
        s.icache_flush_ack = 1'b1; step();
        check("fence_rv", 64'(redirect_valid), 64'd1);
        check("fence_pc", redirect_pc, 64'h8000_0044);
        idle(); step();
        check("fence_run", 64'({if_stall, icache_flush_req}), 64'd0);

        // Mispredict during flush aborts the fence; a late ack is ignored.
        start_fence(64'h8000_0080);
        step();
        s.ex_redirect = 1'b1; s.ex_redirect_pc = 64'h8000_0200; step();
        check("abort_req", 64'(icache_flush_req), 64'd0);
        check("abort_pc", redirect_pc, 64'h8000_0200);
        idle(); s.icache_flush_ack = 1'b1; step();
        check("abort_ack", 64'(redirect_valid), 64'd0);

        // ex_busy with a load-use pending: 8 busy cycles, then one bubble.
        idle(); s.ex_busy = 1'b1; s.ex_is_load = 1'b1; s.ex_rd = 5'd7;
        s.id_rs1_en = 1'b1; s.id_rs1 = 5'd7;
        for (int i = 0; i < 8; i++) begin
            step();
            check("busy", 64'({ex_stall, ex_mem_nop, id_ex_nop}), 64'b110);
        end
        s.ex_busy = 1'b0; step();
        check("busy_then_lu", 64'({ex_stall, id_ex_nop}), 64'b01);
        idle(); step();

        // Reset while waiting on the icache flush.
        start_fence(64'hFFFF_FFFF_FFFF_FFFC);
        step();
        idle(); s.reset = 1'b1; step();
        check("rst_flush", 64'(icache_flush_req), 64'd0);
        idle(); step();
        check("rst_after", 64'({if_stall, icache_flush_req, redirect_valid}), 64'd0);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        check("rst_perf", 64'({perf_stall_cyc, perf_flush_cnt}), 64'd0);
`endif

        // Wrap of fence return address.
        start_fence(64'hFFFF_FFFF_FFFF_FFFC);
        s.icache_flush_ack = 1'b1; step();
        check("wrap_pc", redirect_pc, 64'd0);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            idle();
            s.reset            = ($urandom_range(0, 199) == 0);
            s.mem_busy         = ($urandom_range(0, 6) == 0);
            s.ex_busy          = ($urandom_range(0, 9) == 0);
            s.ex_redirect      = !m_pend && ($urandom_range(0, 19) == 0);
            s.ex_redirect_pc   = {$urandom(), $urandom()};
            s.ex_is_load       = $urandom_range(0, 1) == 1;
            s.ex_rd            = 5'($urandom_range(0, 3));
            s.id_rs1_en        = $urandom_range(0, 1) == 1;
            s.id_rs1           = 5'($urandom_range(0, 3));
            s.id_rs2_en        = $urandom_range(0, 1) == 1;
            s.id_rs2           = 5'($urandom_range(0, 3));
            s.id_fence_i       = ($urandom_range(0, 9) == 0);
            s.id_pc            = {$urandom(), $urandom()};
            s.icache_flush_ack = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
